// File: rtl/puf_auth_ctrl.sv
// Challenge-issuing and verification controller for a ring-oscillator PUF.
// Latches a challenge and enrolled response, clears the PUF counters, runs
// the oscillators for a fixed window, freezes them, captures the count and
// reports the Hamming distance to the enrolled value with a pass verdict.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; results and challenge hold
// CLR     | puf_reset high for 2 cycles to clear the PUF counters
// RUN     | puf_en high for WINDOW cycles
// HOLD    | oscillators frozen for 2 cycles while the response settles
// CAPTURE | single sample of puf_response into resp_q
// EVAL    | compute distance/verdict, update results and pulse done
module puf_auth_ctrl #(
  parameter int WINDOW = 255,
  parameter int THRESH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] chal_in,
  input  logic [7:0] exp_resp,
  output logic       puf_en,
  output logic       puf_reset,
  output logic [9:0] puf_challenge,
  input  logic [7:0] puf_response,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] hd,
  output logic [7:0] resp_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    RUN     = 3'd2,
    HOLD    = 3'd3,
    CAPTURE = 3'd4,
    EVAL    = 3'd5
  } state_t;

  // Counter reload values are "cycles in state minus one"; the state exits
  // on the edge where the counter reads zero.
  localparam logic [15:0] CLR_LOAD  = 16'd1;
  localparam logic [15:0] RUN_LOAD  = 16'(WINDOW - 1);
  localparam logic [15:0] HOLD_LOAD = 16'd1;
  localparam logic [3:0]  THRESH_L  = 4'(THRESH);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  exp_q;
  logic [7:0]  resp_q;
  logic        accept;
  logic        capture_en;
  logic        eval_en;
  logic [3:0]  hd_calc;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // State register and window down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter reload and per-state strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    capture_en = 1'b0;
    eval_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CLR;
          cnt_d   = CLR_LOAD;
        end
      end
      CLR: begin
        if (cnt_q == 16'd0) begin
          state_d = RUN;
          cnt_d   = RUN_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RUN: begin
        if (cnt_q == 16'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = CAPTURE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_d    = EVAL;
      end
      EVAL: begin
        eval_en = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Challenge and enrolled response are only taken on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      puf_challenge <= 10'd0;
      exp_q         <= 8'd0;
    end else if (accept) begin
      puf_challenge <= chal_in;
      exp_q         <= exp_resp;
    end
  end

  // Single sample of the response; the PUF is frozen here so no synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= 8'd0;
    end else if (capture_en) begin
      resp_q <= puf_response;
    end
  end

  // Distance to the enrolled value from the captured sample.
  always_comb begin
    hd_calc = popcount8(resp_q ^ exp_q);
  end

  // Result registers update together with the one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      hd       <= 4'd0;
      resp_out <= 8'd0;
    end else begin
      done <= eval_en;
      if (eval_en) begin
        hd       <= hd_calc;
        pass     <= (hd_calc <= THRESH_L);
        resp_out <= resp_q;
      end
    end
  end

  // Decoded from the state register so puf_en drops as soon as reset clears it.
  always_comb begin
    puf_en    = (state_q == RUN);
    puf_reset = reset | (state_q == CLR);
    busy      = (state_q != IDLE);
  end

endmodule
